// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that steers one shared mux8to1 between eight requesters and
// registers the selected beat into a valid/ready output stage. Optional macro ARB_LOCK_EN adds a lock input.
module mux_rr_arbiter #(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] ack,
    output logic [2:0] sel,
    input  logic [3:0] mux_y,
    output logic [3:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
`ifdef ARB_LOCK_EN
    input  logic       lock,
`endif
    output logic [2:0] owner,
    output logic       busy
);

    // Handshake: a beat is accepted from requester i (ack[i]) in the cycle it is loaded;
    // out_data transfers downstream on any edge where out_valid && out_ready.
    typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

    localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(BURST_LEN - 1);

    state_t           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [2:0]       owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q;
    logic [3:0]       out_data_q;

    logic [2:0] cand;
    logic [2:0] idx;
    logic [2:0] sel_c;
    logic       load;
    logic       space;
    logic       lock_w;

`ifdef ARB_LOCK_EN
    assign lock_w = lock;
`else
    assign lock_w = 1'b0;
`endif

    assign space = !out_valid_q || out_ready;

    // Scan from the highest offset down so the requester closest to ptr wins.
    always_comb begin
        cand = 3'd0;
        idx  = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            idx = ptr_q + 3'(k);
            if (req[idx]) cand = idx;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        sel_c   = owner_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    sel_c = cand;
                    if (space) begin
                        load    = 1'b1;
                        owner_d = cand;
                        if (BURST_LEN == 1) begin
                            ptr_d = cand + 3'd1;
                        end else begin
                            state_d = OWN;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
            end
            OWN: begin
                if (!req[owner_q]) begin
                    state_d = IDLE;
                    ptr_d   = owner_q + 3'd1;
                end else if (space) begin
                    load = 1'b1;
                    if (cnt_q < BURST_CNT) cnt_d = cnt_q + CNT_W'(1);
                    // Compare the pre-increment count so a saturated counter cannot wrap past the limit.
                    if (!lock_w && cnt_q >= LAST_CNT) begin
                        state_d = IDLE;
                        ptr_d   = owner_q + 3'd1;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (!rst_n) load = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 3'd0;
            owner_q     <= 3'd0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            if (load) begin
                out_valid_q <= 1'b1;
                out_data_q  <= mux_y;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign sel       = sel_c;
    assign ack       = load ? (8'd1 << sel_c) : 8'd0;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign owner     = owner_q;
    assign busy      = (state_q == OWN);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios plus randomized traffic against a
// cycle-level reference model of the arbitration rules.
module tb_mux_rr_arbiter;
  localparam int BL = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'd0;
  logic [7:0] ack;
  logic [2:0] sel;
  logic [3:0] mux_y;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [2:0] owner;
  logic       busy;
`ifdef ARB_LOCK_EN
  logic       lock = 1'b0;
`endif

  logic [3:0] data [8];

  int checks = 0;
  int errors = 0;

  // reference model state
  int         m_ptr, m_owner, m_cnt;
  bit         m_busy;
  logic [3:0] m_data;
  logic [3:0] exp_q[$];

  // sampled values: s_* from the DUT, e_* from the model
  logic [7:0] s_ack, e_ack;
  logic [2:0] s_sel, e_sel;
  logic       s_ov, e_ov, s_busy, e_busy;
  logic [3:0] s_od, e_od;
  logic [2:0] s_owner, e_owner;

  always #5 clk = ~clk;

  always_comb mux_y = data[sel];

  mux_rr_arbiter #(.BURST_LEN(BL), .CNT_W(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .ack(ack),
    .sel(sel),
    .mux_y(mux_y),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef ARB_LOCK_EN
    .lock(lock),
`endif
    .owner(owner),
    .busy(busy)
  );

  task automatic model_reset();
    m_ptr = 0;
    m_owner = 0;
    m_cnt = 0;
    m_busy = 0;
    m_data = 4'd0;
    exp_q.delete();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req = 8'd0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: called at a negedge with inputs already driven.
  task automatic tick();
    int  cand;
    bit  any, space, load, pop;
    #1;
    any = (req != 8'd0);
    cand = 0;
    for (int k = 7; k >= 0; k--)
      if (req[(m_ptr + k) % 8]) cand = (m_ptr + k) % 8;
    space = (exp_q.size() == 0) || out_ready;
    pop = (exp_q.size() != 0) && out_ready;
    if (m_busy) begin
      e_sel = 3'(m_owner);
      load = req[m_owner] && space;
    end else begin
      e_sel = any ? 3'(cand) : 3'(m_owner);
      load = any && space;
    end
    e_ack = load ? (8'd1 << e_sel) : 8'd0;
    s_ack = ack;
    s_sel = sel;
    @(posedge clk);
    if (pop) void'(exp_q.pop_front());
    if (load) begin
      exp_q.push_back(data[e_sel]);
      m_data = data[e_sel];
    end
    if (!m_busy) begin
      if (load) begin
        m_owner = cand;
        if (BL == 1) m_ptr = (cand + 1) % 8;
        else begin
          m_busy = 1;
          m_cnt = 1;
        end
      end
    end else if (!req[m_owner]) begin
      m_busy = 0;
      m_ptr = (m_owner + 1) % 8;
    end else if (load) begin
      m_cnt++;
      if (m_cnt >= BL) begin
        m_busy = 0;
        m_ptr = (m_owner + 1) % 8;
      end
    end
    @(negedge clk);
    e_ov = (exp_q.size() != 0);
    e_od = m_data;
    e_owner = 3'(m_owner);
    e_busy = m_busy;
    s_ov = out_valid;
    s_od = out_data;
    s_owner = owner;
    s_busy = busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 8'hFF;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) data[i] = 4'(i);
    model_reset();
    #3;
    checks++;
    if (ack !== 8'd0) begin
      errors++;
      $display("FAIL reset_ack got %h want 00", ack);
    end
    @(negedge clk);
    req = 8'd0;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (s_ack !== 8'd0 || s_sel !== 3'd0) begin
        errors++;
        $display("FAIL reset_idle_comb c%0d ack %h sel %0d want 00 0", c, s_ack, s_sel);
      end
      checks++;
      if (s_ov !== 1'b0 || s_owner !== 3'd0 || s_busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle_reg c%0d valid %b owner %0d busy %b want 0 0 0", c, s_ov, s_owner, s_busy);
      end
    end
  endtask

  task automatic test_single_burst();
    logic [3:0] v;
    apply_reset();
    out_ready = 1'b1;
    req = 8'h08;
    for (int k = 0; k < 5; k++) begin
      v = 4'hA + 4'(k);
      data[3] = v;
      tick();
      checks++;
      if (s_ack !== 8'h08 || s_sel !== 3'd3) begin
        errors++;
        $display("FAIL burst_ack beat%0d ack %h sel %0d want 08 3", k, s_ack, s_sel);
      end
      checks++;
      if (s_ov !== 1'b1 || s_od !== v) begin
        errors++;
        $display("FAIL burst_data beat%0d valid %b data %h want 1 %h", k, s_ov, s_od, v);
      end
    end
    req = 8'd0;
    tick();
    tick();
  endtask

  task automatic test_rotation();
    logic [2:0] want;
    apply_reset();
    out_ready = 1'b1;
    req = 8'h81;
    for (int n = 0; n < 4 * BL; n++) begin
      data[0] = 4'($urandom_range(0, 15));
      data[7] = 4'($urandom_range(0, 15));
      want = ((n / BL) % 2 == 0) ? 3'd0 : 3'd7;
      tick();
      checks++;
      if (s_sel !== want || s_ack !== (8'd1 << want)) begin
        errors++;
        $display("FAIL rotation n%0d sel %0d ack %h want sel %0d", n, s_sel, s_ack, want);
      end
      checks++;
      if (s_od !== e_od || s_owner !== e_owner) begin
        errors++;
        $display("FAIL rotation_reg n%0d data %h owner %0d want %h %0d", n, s_od, s_owner, e_od, e_owner);
      end
    end
    req = 8'd0;
    tick();
  endtask

  task automatic test_backpressure();
    apply_reset();
    out_ready = 1'b1;
    req = 8'h20;
    data[5] = 4'h3;
    tick();
    out_ready = 1'b0;
    data[5] = 4'h9;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (s_ack !== 8'd0 || s_ov !== 1'b1 || s_od !== 4'h3 || s_busy !== 1'b1) begin
        errors++;
        $display("FAIL backpressure c%0d ack %h valid %b data %h busy %b want 00 1 3 1", c, s_ack, s_ov, s_od, s_busy);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (s_ack !== 8'h20 || s_ov !== 1'b1 || s_od !== 4'h9) begin
      errors++;
      $display("FAIL backpressure_release ack %h valid %b data %h want 20 1 9", s_ack, s_ov, s_od);
    end
    req = 8'd0;
    tick();
    tick();
  endtask

  task automatic test_early_drop();
    apply_reset();
    out_ready = 1'b1;
    req = 8'h04;
    data[2] = 4'h5;
    data[6] = 4'hC;
    data[1] = 4'h1;
    tick();
    req = 8'h42;
    tick();
    checks++;
    if (s_ack !== 8'd0 || s_busy !== 1'b0) begin
      errors++;
      $display("FAIL early_drop_bubble ack %h busy %b want 00 0", s_ack, s_busy);
    end
    tick();
    checks++;
    if (s_ack !== 8'h40 || s_sel !== 3'd6 || s_owner !== 3'd6 || s_od !== 4'hC) begin
      errors++;
      $display("FAIL early_drop_regrant ack %h sel %0d owner %0d data %h want 40 6 6 c", s_ack, s_sel, s_owner, s_od);
    end
    req = 8'd0;
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    apply_reset();
    out_ready = 1'b1;
    req = 8'h10;
    tick();
    tick();
    checks++;
    if (s_ov !== 1'b1 || s_owner !== 3'd4 || s_busy !== 1'b1) begin
      errors++;
      $display("FAIL async_pre valid %b owner %0d busy %b want 1 4 1", s_ov, s_owner, s_busy);
    end
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || ack !== 8'd0 || owner !== 3'd0) begin
      errors++;
      $display("FAIL async_during valid %b busy %b ack %h owner %0d want 0 0 00 0", out_valid, busy, ack, owner);
    end
    #1 rst_n = 1'b1;
    req = 8'h11;
    tick();
    checks++;
    if (s_sel !== 3'd0 || s_ack !== 8'h01) begin
      errors++;
      $display("FAIL async_regrant sel %0d ack %h want 0 01", s_sel, s_ack);
    end
    req = 8'd0;
    tick();
    tick();
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 3) == 0) req = 8'($urandom) & 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 8; i++) data[i] = 4'($urandom_range(0, 15));
      tick();
      checks++;
      if (s_ack !== e_ack || s_sel !== e_sel) begin
        errors++;
        $display("FAIL random_comb c%0d ack %h sel %0d want %h %0d", c, s_ack, s_sel, e_ack, e_sel);
      end
      checks++;
      if (s_ov !== e_ov || s_od !== e_od || s_owner !== e_owner || s_busy !== e_busy) begin
        errors++;
        $display("FAIL random_reg c%0d v/d/o/b %b %h %0d %b want %b %h %0d %b",
                 c, s_ov, s_od, s_owner, s_busy, e_ov, e_od, e_owner, e_busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_rotation();
    test_backpressure();
    test_early_drop();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
